// File: rtl/ram_arbiter_pkg.sv
// Shared types for the main-RAM arbiter: read-return owner encoding and the
// width of the CPU starvation counter.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VGA  = 2'd2
  } owner_t;

  localparam int WAIT_W = 4;

endpackage

// File: rtl/arb_stat_counter.sv
// Free-running 32-bit event counter with natural wrap. Only elaborated when
// RAM_ARB_STATS_EN is defined, since nothing else instantiates it.
`ifdef RAM_ARB_STATS_EN
module arb_stat_counter (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        i_en,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;

endmodule
`endif

// File: rtl/ram_arbiter.sv
// Single-port main-RAM arbiter: VGA scan-out has priority, CPU is guaranteed a
// slot after CPU_MAX_WAIT consecutive losses. Optional counters: RAM_ARB_STATS_EN.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 32,
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic                cpu_req_i,
  input  logic                cpu_we_i,
  input  logic [DATA_W/8-1:0] cpu_mask_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [DATA_W-1:0]   cpu_data_i,
  output logic                cpu_gnt_o,
  output logic                cpu_rvalid_o,
  output logic [DATA_W-1:0]   cpu_data_o,
  input  logic                vga_req_i,
  input  logic [ADDR_W-1:0]   vga_addr_i,
  output logic                vga_gnt_o,
  output logic                vga_rvalid_o,
  output logic [DATA_W-1:0]   vga_data_o,
  output logic                ram_sel_o,
  output logic                ram_we_o,
  output logic [DATA_W/8-1:0] ram_mask_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic [DATA_W-1:0]   ram_data_o,
  input  logic [DATA_W-1:0]   ram_data_i
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [31:0]         stat_cpu_grants_o,
  output logic [31:0]         stat_vga_grants_o,
  output logic [31:0]         stat_cpu_stall_o
`endif
);

  localparam logic [WAIT_W-1:0] MAX_WAIT = WAIT_W'(CPU_MAX_WAIT);

  owner_t              r_rd_owner;
  owner_t              w_rd_owner_next;
  logic [WAIT_W-1:0]   r_cpu_wait;
  logic [WAIT_W-1:0]   w_cpu_wait_next;
  logic [DATA_W-1:0]   r_cpu_data;
  logic [DATA_W-1:0]   r_vga_data;
  logic                w_vga_win;
  logic                w_cpu_win;
  logic                w_cpu_rvalid;
  logic                w_vga_rvalid;

  // VGA yields only once the CPU has been starved for CPU_MAX_WAIT cycles.
  assign w_vga_win = vga_req_i & (~cpu_req_i | (r_cpu_wait < MAX_WAIT));
  assign w_cpu_win = cpu_req_i & ~w_vga_win;

  assign cpu_gnt_o = w_cpu_win;
  assign vga_gnt_o = w_vga_win;

  always_comb begin
    ram_sel_o  = 1'b0;
    ram_we_o   = 1'b0;
    ram_mask_o = '0;
    ram_addr_o = '0;
    ram_data_o = '0;
    if (w_vga_win) begin
      ram_sel_o  = 1'b1;
      ram_mask_o = '1;
      ram_addr_o = vga_addr_i;
    end else if (w_cpu_win) begin
      ram_sel_o  = 1'b1;
      ram_we_o   = cpu_we_i;
      ram_mask_o = cpu_mask_i;
      ram_addr_o = cpu_addr_i;
      ram_data_o = cpu_data_i;
    end
  end

  always_comb begin
    w_cpu_wait_next = '0;
    if (cpu_req_i && w_vga_win) begin
      w_cpu_wait_next = (r_cpu_wait == MAX_WAIT) ? r_cpu_wait : r_cpu_wait + 1'b1;
    end

    w_rd_owner_next = OWN_NONE;
    if (w_vga_win) begin
      w_rd_owner_next = OWN_VGA;
    end else if (w_cpu_win && !cpu_we_i) begin
      w_rd_owner_next = OWN_CPU;
    end
  end

  assign w_cpu_rvalid = (r_rd_owner == OWN_CPU);
  assign w_vga_rvalid = (r_rd_owner == OWN_VGA);

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      r_rd_owner <= OWN_NONE;
      r_cpu_wait <= '0;
      r_cpu_data <= '0;
      r_vga_data <= '0;
    end else begin
      r_rd_owner <= w_rd_owner_next;
      r_cpu_wait <= w_cpu_wait_next;
      if (w_cpu_rvalid) begin
        r_cpu_data <= ram_data_i;
      end
      if (w_vga_rvalid) begin
        r_vga_data <= ram_data_i;
      end
    end
  end

  // Return data passes straight through on the rvalid cycle, then is held.
  assign cpu_rvalid_o = w_cpu_rvalid;
  assign vga_rvalid_o = w_vga_rvalid;
  assign cpu_data_o   = w_cpu_rvalid ? ram_data_i : r_cpu_data;
  assign vga_data_o   = w_vga_rvalid ? ram_data_i : r_vga_data;

`ifdef RAM_ARB_STATS_EN
  logic w_cpu_stall;
  assign w_cpu_stall = cpu_req_i & ~w_cpu_win;

  arb_stat_counter u_stat_cpu (
    .clk     (clk),
    .reset_i (reset_i),
    .i_en    (w_cpu_win),
    .o_count (stat_cpu_grants_o)
  );

  arb_stat_counter u_stat_vga (
    .clk     (clk),
    .reset_i (reset_i),
    .i_en    (w_vga_win),
    .o_count (stat_vga_grants_o)
  );

  arb_stat_counter u_stat_stall (
    .clk     (clk),
    .reset_i (reset_i),
    .i_en    (w_cpu_stall),
    .o_count (stat_cpu_stall_o)
  );
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus random traffic
// against a rule-level arbitration model and a reference memory image.
module tb_ram_arbiter;

  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 32;
  localparam int MASK_W   = DATA_W / 8;
  localparam int MAX_WAIT = 4;
  localparam int WORDS    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset_i = 1'b0;
  logic              cpu_req_i = 1'b0, cpu_we_i = 1'b0;
  logic [MASK_W-1:0] cpu_mask_i = '0;
  logic [ADDR_W-1:0] cpu_addr_i = '0;
  logic [DATA_W-1:0] cpu_data_i = '0;
  logic              cpu_gnt_o, cpu_rvalid_o;
  logic [DATA_W-1:0] cpu_data_o;
  logic              vga_req_i = 1'b0;
  logic [ADDR_W-1:0] vga_addr_i = '0;
  logic              vga_gnt_o, vga_rvalid_o;
  logic [DATA_W-1:0] vga_data_o;
  logic              ram_sel_o, ram_we_o;
  logic [MASK_W-1:0] ram_mask_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_data_o;
  logic [DATA_W-1:0] ram_data_i = '0;
`ifdef RAM_ARB_STATS_EN
  logic [31:0] stat_cpu_grants_o, stat_vga_grants_o, stat_cpu_stall_o;
`endif

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CPU_MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset_i(reset_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_mask_i(cpu_mask_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_gnt_o(cpu_gnt_o), .cpu_rvalid_o(cpu_rvalid_o), .cpu_data_o(cpu_data_o),
    .vga_req_i(vga_req_i), .vga_addr_i(vga_addr_i),
    .vga_gnt_o(vga_gnt_o), .vga_rvalid_o(vga_rvalid_o), .vga_data_o(vga_data_o),
    .ram_sel_o(ram_sel_o), .ram_we_o(ram_we_o), .ram_mask_o(ram_mask_o),
    .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
`ifdef RAM_ARB_STATS_EN
    ,
    .stat_cpu_grants_o(stat_cpu_grants_o), .stat_vga_grants_o(stat_vga_grants_o),
    .stat_cpu_stall_o(stat_cpu_stall_o)
`endif
  );

  // RAM device model: synchronous write with byte mask, registered read.
  logic [DATA_W-1:0] ram_mem [0:WORDS-1];
  always @(posedge clk) begin
    if (ram_sel_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < MASK_W; b++)
          if (ram_mask_o[b]) ram_mem[ram_addr_o][8*b +: 8] <= ram_data_o[8*b +: 8];
      end else begin
        ram_data_i <= ram_mem[ram_addr_o];
      end
    end
  end

  // Reference state, derived from the arbitration rules only.
  logic [DATA_W-1:0] ref_mem [0:WORDS-1];
  int                losses;
  bit                exp_cpu_rv, exp_vga_rv;
  logic [DATA_W-1:0] exp_cpu_data, exp_vga_data;
`ifdef RAM_ARB_STATS_EN
  logic [31:0]       st_cpu, st_vga, st_stall;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [DATA_W-1:0] init_word(input int a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic model_reset();
    losses       = 0;
    exp_cpu_rv   = 1'b0;
    exp_vga_rv   = 1'b0;
    exp_cpu_data = '0;
    exp_vga_data = '0;
`ifdef RAM_ARB_STATS_EN
    st_cpu = '0; st_vga = '0; st_stall = '0;
`endif
  endtask

  task automatic check_rd();
    chk("cpu_rvalid", cpu_rvalid_o, exp_cpu_rv);
    chk("cpu_data",   cpu_data_o,   exp_cpu_data);
    chk("vga_rvalid", vga_rvalid_o, exp_vga_rv);
    chk("vga_data",   vga_data_o,   exp_vga_data);
  endtask

  // One clock cycle: entered just after a falling edge, leaves at the next one.
  task automatic drive_cycle(input bit creq, input bit cwe, input logic [MASK_W-1:0] cmask,
                             input logic [ADDR_W-1:0] caddr, input logic [DATA_W-1:0] cdata,
                             input bit vreq, input logic [ADDR_W-1:0] vaddr,
                             output bit cg, output bit vg);
    bit ew_cpu, ew_vga;
    logic [20:0] exp_bus;
    check_rd();
    cpu_req_i = creq; cpu_we_i = cwe; cpu_mask_i = cmask;
    cpu_addr_i = caddr; cpu_data_i = cdata;
    vga_req_i = vreq; vga_addr_i = vaddr;
    #1;
    ew_vga = vreq && (!creq || losses < MAX_WAIT);
    ew_cpu = creq && !ew_vga;
    chk("cpu_gnt", cpu_gnt_o, ew_cpu);
    chk("vga_gnt", vga_gnt_o, ew_vga);
    if (ew_vga)      exp_bus = {1'b1, 1'b0, {MASK_W{1'b1}}, vaddr};
    else if (ew_cpu) exp_bus = {1'b1, cwe, cmask, caddr};
    else             exp_bus = '0;
    chk("ram_bus", {ram_sel_o, ram_we_o, ram_mask_o, ram_addr_o}, exp_bus);
    if (ew_cpu && cwe) chk("ram_wdata", ram_data_o, cdata);
    if (!ew_cpu && !ew_vga) chk("ram_idle_data", ram_data_o, 0);
    cg = cpu_gnt_o;
    vg = vga_gnt_o;

    if (creq && ew_vga) losses = (losses < MAX_WAIT) ? losses + 1 : MAX_WAIT;
    else                losses = 0;
    exp_cpu_rv = ew_cpu && !cwe;
    exp_vga_rv = ew_vga;
    if (ew_vga) begin
      exp_vga_data = ref_mem[vaddr];
      $display("txn vga rd addr=%h data=%h", vaddr, ref_mem[vaddr]);
    end
    if (ew_cpu && !cwe) begin
      exp_cpu_data = ref_mem[caddr];
      $display("txn cpu rd addr=%h data=%h", caddr, ref_mem[caddr]);
    end
    if (ew_cpu && cwe) begin
      for (int b = 0; b < MASK_W; b++)
        if (cmask[b]) ref_mem[caddr][8*b +: 8] = cdata[8*b +: 8];
      $display("txn cpu wr addr=%h data=%h mask=%b", caddr, cdata, cmask);
    end
`ifdef RAM_ARB_STATS_EN
    if (ew_cpu) st_cpu = st_cpu + 1;
    if (ew_vga) st_vga = st_vga + 1;
    if (creq && !ew_cpu) st_stall = st_stall + 1;
`endif
    @(negedge clk);
  endtask

  task automatic idle();
    bit cg, vg;
    drive_cycle(0, 0, '0, '0, '0, 0, '0, cg, vg);
  endtask

  task automatic reset_pulse();
    cpu_req_i = 0; vga_req_i = 0; cpu_we_i = 0;
    cpu_mask_i = '0; cpu_addr_i = '0; cpu_data_i = '0; vga_addr_i = '0;
    reset_i = 1'b0;
    model_reset();
    #1;
    chk("rst_cpu_outs", {cpu_gnt_o, cpu_rvalid_o, cpu_data_o}, 0);
    chk("rst_vga_outs", {vga_gnt_o, vga_rvalid_o, vga_data_o}, 0);
    chk("rst_ram_outs", {ram_sel_o, ram_we_o, ram_mask_o, ram_addr_o, ram_data_o}, 0);
    @(posedge clk);
    @(negedge clk);
    reset_i = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit cg, vg, c_pend, c_we, v_pend, vsel;
    int ncg, nvg, first_cpu;
    logic [MASK_W-1:0] c_mask;
    logic [ADDR_W-1:0] c_addr, v_addr;
    logic [DATA_W-1:0] c_data, w20;

    for (int a = 0; a < WORDS; a++) begin
      ram_mem[a] = init_word(a);
      ref_mem[a] = init_word(a);
    end
    ram_mem[16'h0010] = 32'hDEADBEEF;
    ref_mem[16'h0010] = 32'hDEADBEEF;
    w20 = init_word(32'h20);

    @(negedge clk);
    reset_pulse();

    // CPU-only read returns the preloaded word one cycle later
    drive_cycle(1, 0, 4'hF, 15'h0010, '0, 0, '0, cg, vg);
    chk("t1_gnt", cg, 1);
    chk("t1_data", cpu_data_o, 32'hDEADBEEF);
    chk("t1_vga_rv", vga_rvalid_o, 0);
    idle();

    // masked write, then read back merged word
    drive_cycle(1, 1, 4'b0011, 15'h0020, 32'h12345678, 0, '0, cg, vg);
    chk("t2_no_rvalid", cpu_rvalid_o, 0);
    drive_cycle(1, 0, 4'hF, 15'h0020, '0, 0, '0, cg, vg);
    chk("t2_readback", cpu_data_o, {w20[31:16], 16'h5678});
    idle();

    // continuous contention: 4 VGA grants then 1 CPU grant
    ncg = 0; nvg = 0;
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1, 0, 4'hF, 15'h0030, '0, 1, 15'h0040, cg, vg);
      ncg += int'(cg); nvg += int'(vg);
    end
    chk("t3_cpu_grants", ncg, 4);
    chk("t3_vga_grants", nvg, 16);

    // alternating VGA lines with one CPU read in between
    c_pend = 1; vsel = 0;
    for (int i = 0; i < 12; i++) begin
      drive_cycle(c_pend, 0, 4'hF, 15'h0200, '0, 1, vsel ? 15'h0101 : 15'h0100, cg, vg);
      if (cg) c_pend = 0;
      if (vg) vsel = !vsel;
    end
    idle();

    // reset right after a VGA grant, with both requesters still active
    for (int i = 0; i < 3; i++) drive_cycle(1, 0, 4'hF, 15'h0300, '0, 1, 15'h0301, cg, vg);
    reset_i = 1'b0;
    model_reset();
    #1;
    check_rd();
    @(posedge clk);
    @(negedge clk);
    reset_i = 1'b1;
    first_cpu = 0;
    for (int i = 1; i <= 6; i++) begin
      drive_cycle(1, 0, 4'hF, 15'h0300, '0, 1, 15'h0301, cg, vg);
      if (cg && first_cpu == 0) first_cpu = i;
    end
    chk("rst_wait_cleared", first_cpu, MAX_WAIT + 1);
    reset_pulse();

    // random traffic with hold-until-grant and occasional cancellation
    c_pend = 0; v_pend = 0;
    c_we = 0; c_mask = '1; c_addr = '0; c_data = '0; v_addr = '0;
    for (int i = 0; i < 1200; i++) begin
      if (!c_pend && $urandom_range(0, 99) < 60) begin
        c_pend = 1;
        c_we   = ($urandom_range(0, 99) < 35);
        c_mask = MASK_W'($urandom_range(1, (1 << MASK_W) - 1));
        c_addr = ($urandom_range(0, 9) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 63));
        c_data = $urandom;
      end else if (c_pend && $urandom_range(0, 99) < 4) begin
        c_pend = 0;
      end
      if (!v_pend && $urandom_range(0, 99) < 70) begin
        v_pend = 1;
        v_addr = ADDR_W'($urandom_range(0, 63));
      end
      drive_cycle(c_pend, c_we, c_mask, c_addr, c_data, v_pend, v_addr, cg, vg);
      if (cg) c_pend = 0;
      if (vg) v_pend = 0;
    end
    idle();

`ifdef RAM_ARB_STATS_EN
    chk("stat_cpu_model", stat_cpu_grants_o, st_cpu);
    chk("stat_vga_model", stat_vga_grants_o, st_vga);
    chk("stat_stall_model", stat_cpu_stall_o, st_stall);
    reset_pulse();
    for (int i = 0; i < 3; i++)  drive_cycle(1, 0, 4'hF, 15'h0005, '0, 1, 15'h0006, cg, vg);
    for (int i = 0; i < 3; i++)  drive_cycle(0, 0, 4'hF, '0, '0, 1, 15'h0007, cg, vg);
    for (int i = 0; i < 10; i++) drive_cycle(1, 0, 4'hF, ADDR_W'(i), '0, 0, '0, cg, vg);
    chk("stat_cpu_10", stat_cpu_grants_o, 10);
    chk("stat_vga_6", stat_vga_grants_o, 6);
    chk("stat_stall_3", stat_cpu_stall_o, 3);
    force dut.u_stat_vga.r_count = 32'hFFFFFFFF;
    #1;
    release dut.u_stat_vga.r_count;
    st_vga = 32'hFFFFFFFF;
    drive_cycle(0, 0, 4'hF, '0, '0, 1, 15'h0008, cg, vg);
    chk("stat_vga_wrap", stat_vga_grants_o, 0);
    chk("stat_vga_wrap_model", stat_vga_grants_o, st_vga);
`endif

    check_rd();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port main RAM (selected when addr[31:28]==4'h1) between two requesters: the CPU memory bus and the VGA scan-out fetch port (vram_* interface).
- The VGA port has priority because its traffic is real-time. A starvation guard bounds CPU wait.
- The block sits between processor/vga and the bram/spram instance. It owns sel, we, mask, addr and data toward the RAM.
- Read data returns one cycle after grant.

Parameters:
- ADDR_W, 15: RAM word-address width.
- DATA_W, 32: data width. Must be a multiple of 8.
- CPU_MAX_WAIT, 4: maximum consecutive cycles a requesting CPU may lose to VGA. Range 1..15.

Ports:
- clk  in  1  system clock
- reset_i  in  1  asynchronous reset, active-low
- cpu_req_i  in  1  CPU access request, held until granted
- cpu_we_i  in  1  1 = write, 0 = read
- cpu_mask_i  in  DATA_W/8  byte write mask
- cpu_addr_i  in  ADDR_W  word address
- cpu_data_i  in  DATA_W  write data
- cpu_gnt_o  out  1  CPU access issued this cycle
- cpu_rvalid_o  out  1  cpu_data_o valid (reads only)
- cpu_data_o  out  DATA_W  read data
- vga_req_i  in  1  VGA read request, held until granted
- vga_addr_i  in  ADDR_W  word address
- vga_gnt_o  out  1  VGA access issued this cycle
- vga_rvalid_o  out  1  vga_data_o valid
- vga_data_o  out  DATA_W  read data
- ram_sel_o  out  1  RAM select
- ram_we_o  out  1  RAM write enable
- ram_mask_o  out  DATA_W/8  RAM byte mask
- ram_addr_o  out  ADDR_W  RAM address
- ram_data_o  out  DATA_W  RAM write data
- ram_data_i  in  DATA_W  RAM read data, valid one cycle after sel

Behaviour:
- Reset (reset_i low, asynchronous) sets all registered state and outputs to 0:
  - rvalid flags
  - rd_owner_q = OWN_NONE
  - cpu_wait_q
  - captured read data
- Grant is combinational in the request cycle. At most one grant per cycle. ram_* are driven from the winner in the same cycle.
- With no winner, ram_sel_o=0 and ram_we_o=0. ram_addr_o, ram_data_o and ram_mask_o are 0.
- VGA always drives ram_we_o=0 and ram_mask_o=all-ones.
- Winner selection:
  - Only one requester: that requester wins.
  - Both requesting and cpu_wait_q < CPU_MAX_WAIT: VGA wins.
  - Both requesting and cpu_wait_q == CPU_MAX_WAIT: CPU wins.
- cpu_wait_q update:
  - Increments when cpu_req_i=1 and VGA wins. Saturates at CPU_MAX_WAIT.
  - Clears when CPU is granted or cpu_req_i=0.
- Read pipeline: rd_owner_q ∈ {OWN_NONE, OWN_CPU, OWN_VGA}.
  - On cycle N it records the read winner. A CPU write records OWN_NONE.
  - In cycle N+1, the owner's rvalid_o=1 for exactly one cycle and data_o=ram_data_i.
  - data_o holds the last read value until the next rvalid for that port.
- Back-to-back grants are allowed every cycle, giving full throughput. Read latency is fixed at 1 cycle after gnt.
- Requesters must hold req/addr/data/we/mask stable until they see gnt. Dropping req before gnt is legal and cancels the request without side effects.
- A CPU write is committed in its grant cycle. No rvalid follows a write.
- Reset mid-read: a pending rvalid is suppressed. The RAM result of that cycle is discarded.

Optional Feature:
- RAM_ARB_STATS_EN defined:
  - Adds outputs stat_cpu_grants_o[31:0], stat_vga_grants_o[31:0] and stat_cpu_stall_o[31:0].
  - The first two count grants per port. stat_cpu_stall_o counts cycles with cpu_req_i=1 and no CPU grant.
  - Counters are free-running, wrap from 0xFFFFFFFF to 0, and reset to 0.
- Undefined: these ports and counters do not exist. Arbitration is unchanged.

Decomposition:
- Package ram_arbiter_pkg holds:
  - typedef enum logic [1:0] owner_t {OWN_NONE, OWN_CPU, OWN_VGA}
  - localparam WAIT_W = 4 (width of cpu_wait_q)
- Sub-module arb_stat_counter (32-bit enable counter with wrap) is instantiated three times under RAM_ARB_STATS_EN. No other sub-modules.

Test Plan:
- CPU-only read at addr 0x0010 (RAM preloaded with 0xDEADBEEF) -> cpu_gnt_o=1 in the same cycle; next cycle cpu_rvalid_o=1, cpu_data_o=0xDEADBEEF; vga_rvalid_o stays 0.
- CPU write addr 0x0020, data 0x12345678, mask 4'b0011 -> ram_we_o=1, ram_mask_o=4'b0011 in the grant cycle; no cpu_rvalid_o; a later read returns 0x????5678 with the upper bytes unchanged.
- VGA and CPU requesting continuously with CPU_MAX_WAIT=4 -> VGA granted 4 cycles, CPU granted on the 5th, pattern repeats (4:1); cpu_wait_q never exceeds 4.
- Alternating VGA reads at 0x0100/0x0101 with a CPU read at 0x0200 -> every rvalid routes to the correct port with the matching word; no cycle has two grants.
- Assert reset_i=0 asynchronously in the cycle after a VGA grant -> vga_rvalid_o=0 immediately, all outputs 0, cpu_wait_q=0; normal arbitration resumes after release.
- With RAM_ARB_STATS_EN: 10 CPU grants, 6 VGA grants, 3 stalled cycles -> counters read 10/6/3; stat_vga_grants_o preset by force to 0xFFFFFFFF plus one grant -> 0.
